// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: requester handshake, ROM read port and tagged response.
// master = requesters + ROM side, slave = the arbiter.
interface sprite_rom_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 14,
    parameter int DW   = 5
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;

    modport master (
        output req, addr, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, addr, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one 1-cycle synchronous ROM read port between NREQ
// sprite-fetch engines. One grant per edge, response two edges after the grant.
// Optional macro SPRITE_ARB_FIXED_PRIO_EN: lowest index always wins (no ptr);
// otherwise round-robin starting from ptr.

// Per-requester address qualification: flags out-of-range addresses and
// substitutes address 0 so the ROM is still read with a legal address.
module sprite_rom_arbiter_lane #(
    parameter int AW    = 14,
    parameter int DEPTH = 16384
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rd_addr,
    output logic          oor
);
    // One extra bit so DEPTH == 2**AW (no out-of-range words) is representable.
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    assign oor     = ({1'b0, addr} >= LIMIT);
    assign rd_addr = oor ? '0 : addr;
endmodule

module sprite_rom_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 14,
    parameter int DW    = 5,
    parameter int DEPTH = 16384
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    sprite_rom_arbiter_if.slave   bus
);
    localparam int IW     = $clog2(NREQ);
    // Stage 0: grant/address, stage 1: ROM read in progress, stage 2: response.
    localparam int STAGES = 2;

    logic [NREQ-1:0][AW-1:0] lane_addr;
    logic [NREQ-1:0][AW-1:0] lane_rd;
    logic [NREQ-1:0]         lane_oor;

    logic                    found;
    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           cand;
    logic [NREQ-1:0]         win_oh;

    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0]             err_pipe;
    logic [STAGES:0][NREQ-1:0]   id_pipe;
    logic [AW-1:0]               rom_addr_q;
    logic [DW-1:0]               rsp_data_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane_addr[i] = bus.addr[i*AW +: AW];

        sprite_rom_arbiter_lane #(
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_lane (
            .addr    (lane_addr[i]),
            .rd_addr (lane_rd[i]),
            .oor     (lane_oor[i])
        );
    end

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest active index wins, so requester 0 is never delayed.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        win_oh  = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            cand = IW'(k);
            if (bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) win_oh[win_idx] = 1'b1;
    end
`else
    logic [IW-1:0] ptr;

    // Round-robin: first active requester at or after ptr (wrapping) wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        win_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) win_oh[win_idx] = 1'b1;
    end

    // Priority pointer moves just past the winner; held on idle cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            ptr <= '0;
        else if (found)
            ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
`endif

    // Valid/id/err shift down the pipeline; reset drops anything in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], found};
            err_pipe <= {err_pipe[STAGES-1:0], found & lane_oor[win_idx]};
            id_pipe  <= {id_pipe[STAGES-1:0], win_oh};
        end
    end

    // ROM address register: loaded on a grant, otherwise holds its last value.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            rom_addr_q <= '0;
        else if (found)
            rom_addr_q <= lane_rd[win_idx];
    end

    // Response data capture; out-of-range reads return 0 regardless of ROM word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            rsp_data_q <= '0;
        else
            rsp_data_q <= (vld_pipe[STAGES-1] && !err_pipe[STAGES-1]) ? bus.rom_data : '0;
    end

    assign bus.gnt       = id_pipe[0];
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = vld_pipe[STAGES] ? id_pipe[STAGES] : '0;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = err_pipe[STAGES];
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: behavioural ROM, cycle-level arbitration model
// and a response scoreboard keyed by due cycle.
module tb_sprite_rom_arbiter;
    localparam int NREQ  = 4;
    localparam int AW    = 14;
    localparam int DW    = 5;
    localparam int DEPTH = 9216;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sprite_rom_arbiter #(
        .NREQ  (NREQ),
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // ROM contents as a function of address; word 0 is non-zero on purpose.
    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return (a[4:0] ^ a[9:5] ^ {1'b0, a[13:10]}) + 5'd7;
    endfunction

    logic [DW-1:0] rom_q;
    always @(posedge Clk) rom_q <= romf(bus.rom_addr);
    assign bus.rom_data = rom_q;

    logic [NREQ-1:0]         req_r;
    logic [NREQ-1:0]         keep;
    logic [NREQ-1:0][AW-1:0] addr_r;
    assign bus.req  = req_r;
    assign bus.addr = addr_r;

    typedef struct {
        logic [NREQ-1:0] id;
        logic [DW-1:0]   data;
        logic            err;
        int              due;
    } rsp_t;
    rsp_t sb[$];

    int errors, checks, cyc, m_ptr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected winner; fixed-priority mode is the same search with ptr pinned at 0.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // One clock: predict grant, check it after the edge, queue its response,
    // and check whatever response is due this cycle.
    task automatic tick();
        int w;
        logic [AW-1:0] a;
        logic oor;
        rsp_t e;
        w = pick(req_r, m_ptr);
        @(posedge Clk);
        #1;
        cyc++;
        if (w >= 0) begin
            a   = addr_r[w];
            oor = (int'(a) >= DEPTH);
            chk("gnt", 32'(bus.gnt), 32'(1) << w);
            chk("rom_addr", 32'(bus.rom_addr), oor ? 32'd0 : 32'(a));
            e.id     = '0;
            e.id[w]  = 1'b1;
            e.data   = oor ? '0 : romf(a);
            e.err    = oor;
            e.due    = cyc + 2;
            sb.push_back(e);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            m_ptr = (w + 1) % NREQ;
`endif
            if (!keep[w]) req_r[w] = 1'b0;
        end else begin
            chk("gnt_idle", 32'(bus.gnt), 32'd0);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.id));
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end else begin
            chk("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    initial begin
        int guard;
        errors = 0;
        checks = 0;
        cyc    = 0;
        m_ptr  = 0;
        req_r  = '0;
        keep   = '0;
        addr_r = '0;

        // reset state
        repeat (2) @(posedge Clk);
        #1;
        chk_all_zero("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // single request
        addr_r[0] = 14'h0123;
        req_r     = 4'b0001;
        repeat (4) tick();

        // all requesters held
        addr_r[0] = 14'h0100;
        addr_r[1] = 14'h0201;
        addr_r[2] = 14'h0302;
        addr_r[3] = 14'h0403;
        keep  = 4'b1111;
        req_r = 4'b1111;
        repeat (5) tick();
        keep  = '0;
        req_r = '0;
        repeat (3) tick();

        // requesters 0 and 2 held, then 0 drops
        keep  = 4'b0101;
        req_r = 4'b0101;
        repeat (4) tick();
        keep[0]  = 1'b0;
        req_r[0] = 1'b0;
        tick();
        keep  = '0;
        tick();
        repeat (3) tick();

        // out-of-range address then last valid word
        addr_r[1] = 14'(9216);
        req_r     = 4'b0010;
        repeat (3) tick();
        addr_r[1] = 14'(9215);
        req_r     = 4'b0010;
        repeat (3) tick();

        // grant to 2, two idle cycles, then everyone
        addr_r[2] = 14'h1ABC;
        req_r     = 4'b0100;
        repeat (3) tick();
        req_r = 4'b1111;
        repeat (6) tick();

        // reset pulse between grant and ROM read
        addr_r[0] = 14'h0055;
        req_r     = 4'b0001;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        m_ptr = 0;
        #1 Reset_n = 1'b1;
        repeat (3) tick();
        req_r = 4'b1111;
        repeat (6) tick();

        // random traffic with proper hold discipline
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_r[i] && $urandom_range(0, 2) == 0) begin
                    addr_r[i] = 14'($urandom_range(0, 16383));
                    req_r[i]  = 1'b1;
                end
            end
            tick();
        end
        guard = 0;
        while ((req_r != '0 || sb.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
